jedro_1_ifu: RTL and testbench

JEDRO_1_IFU -- requirements
Module: jedro_1_ifu

---
 rtl/jedro_1_defines.sv | 18 +
 rtl/jedro_1_ifu_fifo.sv | 58 +++++
 rtl/jedro_1_ifu.sv | 133 +++++++++++++
 tb/tb_jedro_1_ifu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jedro_1_defines.sv
// Shared types for the jedro_1 instruction fetch unit: fetch FSM states and the
// prefetch FIFO entry (instruction word plus its byte address).
package jedro_1_defines;

  localparam int unsigned IFU_XLEN = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [IFU_XLEN-1:0] instr;
    logic [IFU_XLEN-1:0] addr;
  } ifu_entry_t;

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Prefetch buffer for the IFU: synchronous FIFO with a synchronous clear that
// empties it in one cycle. Push and pop may happen in the same cycle, even when full.
module jedro_1_ifu_fifo
  import jedro_1_defines::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  ifu_entry_t             data_i,
  input  logic                   pop_i,
  output ifu_entry_t             head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  ifu_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch unit: sequential prefetch into a small FIFO with redirect.
// Define JEDRO_1_IFU_MISALIGN_EN to reject misaligned redirects and report them on misalign_o.
module jedro_1_ifu
  import jedro_1_defines::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_en_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  jmp_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i
`ifdef JEDRO_1_IFU_MISALIGN_EN
  ,
  output logic                  misalign_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  rsp_pending_q, rsp_pending_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q;
  logic                  jmp_take;
  logic [ADDR_WIDTH-1:0] jmp_tgt;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  ifu_entry_t            push_entry;
  ifu_entry_t            head_entry;

`ifdef JEDRO_1_IFU_MISALIGN_EN
  logic misalign_q;

  assign jmp_take = jmp_i && (jmp_addr_i[1:0] == 2'b00);
  assign jmp_tgt  = jmp_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= jmp_i && (jmp_addr_i[1:0] != 2'b00);
  end

  assign misalign_o = misalign_q;
`else
  assign jmp_take = jmp_i;
  assign jmp_tgt  = jmp_addr_i & ~ADDR_WIDTH'(3);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // A redirect always (re)enters FLUSH so the response already on the bus is dropped.
  always_comb begin
    state_d = state_q;
    if (jmp_take) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rsp_pending_q};

  always_comb begin
    imem_en_o = 1'b0;
    if (state_q == RUN) imem_en_o = (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  end

  assign imem_addr_o = pc_q;

  always_comb begin
    pc_d          = pc_q;
    rsp_pending_d = imem_en_o && !jmp_take;
    if (jmp_take)       pc_d = jmp_tgt;
    else if (imem_en_o) pc_d = pc_q + ADDR_WIDTH'(4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= BOOT_ADDR;
      rsp_pending_q <= 1'b0;
      rsp_addr_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_addr_q    <= pc_q;
    end
  end

  // A redirect clears the FIFO, so both the arriving word and any coincident pop are dropped.
  assign fifo_push        = rsp_pending_q && !jmp_take;
  assign fifo_pop         = instr_valid_o && instr_ready_i && !jmp_take;
  assign push_entry.instr = imem_rdata_i;
  assign push_entry.addr  = rsp_addr_q;

  jedro_1_ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (jmp_take),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head_entry),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? '0 : head_entry.instr;
  assign instr_addr_o  = fifo_empty ? '0 : head_entry.addr;

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Self-checking bench for jedro_1_ifu: directed scenarios plus random ready/redirect traffic,
// checked against an in-order instruction stream model and an address-derived memory image.
module tb_jedro_1_ifu;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = '0;
  logic        jmp_i = 1'b0;
  logic [31:0] jmp_addr_i = '0;
  logic [31:0] instr_o;
  logic [31:0] instr_addr_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
`ifdef JEDRO_1_IFU_MISALIGN_EN
  logic        misalign_o;
`endif

  int          nChecks = 0;
  int          nFails  = 0;
  int          reqCount;
  logic [31:0] expNext;
  logic [31:0] popLog[$];
  logic        obsEn, obsValid, obsMis;
  logic [31:0] obsAddr, obsIaddr, obsInstr;

  always #5 clk = ~clk;

  jedro_1_ifu dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .jmp_i         (jmp_i),
    .jmp_addr_i    (jmp_addr_i),
    .instr_o       (instr_o),
    .instr_addr_o  (instr_addr_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i)
`ifdef JEDRO_1_IFU_MISALIGN_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  // Memory image: every word is a fixed scramble of its own address.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, observe at negedge, update the stream model, answer memory.
  task automatic applyStimulus(input logic jmp, input logic [31:0] tgt, input logic rdy);
    logic        taken;
    logic [31:0] eff;
    jmp_i         = jmp;
    jmp_addr_i    = tgt;
    instr_ready_i = rdy;
    @(negedge clk);
    obsEn    = imem_en_o;
    obsAddr  = imem_addr_o;
    obsValid = instr_valid_o;
    obsIaddr = instr_addr_o;
    obsInstr = instr_o;
`ifdef JEDRO_1_IFU_MISALIGN_EN
    obsMis = misalign_o;
    taken  = jmp && (tgt[1:0] == 2'b00);
    eff    = tgt;
`else
    obsMis = 1'b0;
    taken  = jmp;
    eff    = {tgt[31:2], 2'b00};
`endif
    if (obsEn) reqCount++;
    if (taken) begin
      expNext = eff;
    end else if (obsValid && rdy) begin
      checkOutput("popAddr", obsIaddr, expNext);
      checkOutput("popData", obsInstr, memFn(expNext));
      popLog.push_back(obsIaddr);
      expNext = expNext + 32'd4;
    end
    @(posedge clk);
    #1;
    imem_rdata_i = obsEn ? memFn(obsAddr) : $urandom;
    jmp_i        = 1'b0;
  endtask

  task automatic doReset();
    rst_i         = 1'b1;
    jmp_i         = 1'b0;
    jmp_addr_i    = '0;
    instr_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstEn",    {31'b0, imem_en_o}, 32'd0);
    checkOutput("rstValid", {31'b0, instr_valid_o}, 32'd0);
    checkOutput("rstInstr", instr_o, 32'd0);
    checkOutput("rstIaddr", instr_addr_o, 32'd0);
    @(posedge clk);
    #1;
    rst_i    = 1'b0;
    expNext  = 32'h0;
    reqCount = 0;
    popLog.delete();
  endtask

  initial begin
    logic        jr;
    logic        rr;
    logic [31:0] tg;

    // Boot: first fetch at 0, first valid three cycles after release, one word per cycle.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bootIdle", {31'b0, obsEn}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bootFirstEn", {31'b0, obsEn}, 32'd1);
    checkOutput("bootFirstAddr", obsAddr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bootNotYetValid", {31'b0, obsValid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("bootValid", {31'b0, obsValid}, 32'd1);
      checkOutput("bootSeqAddr", obsIaddr, 32'(i * 4));
    end

    // Redirect while streaming: gap of three cycles, then the target.
    applyStimulus(1'b1, 32'h100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("redirGap", {31'b0, obsValid}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redirValid", {31'b0, obsValid}, 32'd1);
    checkOutput("redirAddr", obsIaddr, 32'h100);

    // Backpressure: four requests fill the buffer, then the fetch stalls.
    doReset();
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("bpReqCount", 32'(reqCount), 32'd4);
    checkOutput("bpEnLow", {31'b0, obsEn}, 32'd0);
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bpFourth", (popLog.size() >= 4) ? popLog[3] : 32'hDEAD_BEEF, 32'hC);

    // Redirect coinciding with a pop on a full buffer: pop suppressed, buffer empty next.
    doReset();
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("jpFull", {31'b0, obsValid}, 32'd1);
    applyStimulus(1'b1, 32'h200, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("jpEmpty", {31'b0, obsValid}, 32'd0);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("jpFirst", (popLog.size() >= 1) ? popLog[0] : 32'hDEAD_BEEF, 32'h200);

    // Address wrap at the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
    popLog.delete();
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap0", (popLog.size() >= 3) ? popLog[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    checkOutput("wrap1", (popLog.size() >= 3) ? popLog[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    checkOutput("wrap2", (popLog.size() >= 3) ? popLog[2] : 32'hDEAD_BEEF, 32'h0);

    // Misaligned redirect target.
    popLog.delete();
    applyStimulus(1'b1, 32'h102, 1'b1);
`ifdef JEDRO_1_IFU_MISALIGN_EN
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("misFlag", {31'b0, obsMis}, 32'd1);
    checkOutput("misStream", {31'b0, obsValid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("misFlagOff", {31'b0, obsMis}, 32'd0);
    checkOutput("misStream", {31'b0, obsValid}, 32'd1);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1);
`else
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("alignForce", (popLog.size() >= 1) ? popLog[0] : 32'hDEAD_BEEF, 32'h100);
`endif

    // Random ready/redirect traffic against the stream model.
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      jr = ($urandom_range(0, 19) == 0);
      tg = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 3) == 0) tg = tg | 32'h2;
      applyStimulus(jr, tg, rr);
    end

    // Reset in the middle of streaming: no stale word survives.
    doReset();
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rerstFirst", (popLog.size() >= 1) ? popLog[0] : 32'hDEAD_BEEF, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
